// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start qualification, mid-bit sampling.
// Define UART_RX_MAJORITY_EN to take each bit sample as a 2-of-3 majority vote.
module uart_rx #(
  parameter int clk_freq = 24000000,
  parameter int baud     = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int DIV  = clk_freq / baud;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic [7:0]    data_nx;
  logic          valid_nx, err_nx;
  logic          rx_meta, rxs, rxs_prev;
  logic          sample, expiry;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rxs};
  end

  // A single-cycle spike on the line cannot flip the vote.
  assign sample = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rxs;
`endif

  assign expiry  = (cnt == '0);
  assign rx_busy = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    data_nx  = rx_data;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rxs_prev && !rxs) begin
          state_nx = START;
          cnt_nx   = HALF_M1;
        end
      end
      START: begin
        if (!expiry) begin
          cnt_nx = cnt - 1'b1;
        end else if (!sample) begin
          state_nx = DATA;
          cnt_nx   = DIV_M1;
          idx_nx   = 3'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (!expiry) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          shift_nx = {sample, shift[7:1]};
          cnt_nx   = DIV_M1;
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (!expiry) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          state_nx = IDLE;
          if (sample) begin
            data_nx  = shift;
            valid_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= 3'd0;
      shift        <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      shift        <= shift_nx;
      rx_data      <= data_nx;
      rx_valid     <= valid_nx;
      rx_frame_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes against a frame-level model.
module tb_uart_rx;

  localparam int CLK_FREQ = 24000000;
  localparam int BAUD     = 1000000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
  localparam int LAT      = 2 + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.clk_freq(CLK_FREQ), .baud(BAUD)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned cyc            = 0;
  int unsigned valid_n        = 0;
  int unsigned err_n          = 0;
  int unsigned both_n         = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned start_cyc      = 0;
  logic [7:0]  got_q[$];

  // Reference model: what the line carried, frame by frame.
  logic [7:0]  exp_q[$];
  int unsigned exp_err_n = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_n++;
      got_q.push_back(rx_data);
      last_valid_cyc = cyc;
    end
    if (rx_frame_err) err_n++;
    if (rx_valid && rx_frame_err) both_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * DIV) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting at a falling clock edge. With spike set, each
  // data bit is inverted for one clock in the middle of its bit period.
  task automatic send(input logic [7:0] b, input logic stop, input bit spike);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (spike) begin
        repeat (HALF) @(negedge clk);
        rx = ~b[k];
        @(negedge clk);
        rx = b[k];
        repeat (DIV - HALF - 1) @(negedge clk);
      end else begin
        repeat (DIV) @(negedge clk);
      end
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int unsigned v0, e0, lat, waited;
    logic [7:0]  b, spike_exp;
    logic        stop_ok;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  rx_data,      8'h00);
    check("reset_valid", rx_valid,     1'b0);
    check("reset_err",   rx_frame_err, 1'b0);
    check("reset_busy",  rx_busy,      1'b0);
    rst = 1'b0;
    idle_bits(1);

    // Single frame with latency measurement.
    send(8'h55, 1'b1, 1'b0);
    exp_q.push_back(8'h55);
    idle_bits(1);
    check("f55_valid_n", valid_n, 1);
    check("f55_err_n",   err_n,   0);
    check("f55_data",    rx_data, 8'h55);
    lat = last_valid_cyc - start_cyc;
    check("f55_latency_in_window", (lat + 1 >= LAT) && (lat <= LAT + 1), 1'b1);

    // Back-to-back frames, one stop bit between them.
    send(8'hA3, 1'b1, 1'b0);
    exp_q.push_back(8'hA3);
    check("a3_data", rx_data, 8'hA3);
    send(8'h00, 1'b1, 1'b0);
    exp_q.push_back(8'h00);
    idle_bits(1);
    check("b2b_valid_n", valid_n, 3);
    check("b2b_data",    rx_data, 8'h00);

    // Framing error followed by a long break, then recovery.
    v0 = valid_n;
    send(8'h7E, 1'b0, 1'b0);
    exp_err_n++;
    rx = 1'b0;
    repeat (30 * DIV) @(negedge clk);
    idle_bits(2);
    check("ferr_err_n",   err_n,   exp_err_n);
    check("ferr_valid_n", valid_n, v0);
    check("ferr_data",    rx_data, 8'h00);
    send(8'h12, 1'b1, 1'b0);
    exp_q.push_back(8'h12);
    idle_bits(1);
    check("after_break_data", rx_data, 8'h12);

    // Short glitch on an idle line.
    v0 = valid_n;
    e0 = err_n;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy", rx_busy, 1'b1);
    waited = 0;
    while (rx_busy && waited < 15) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_idle", rx_busy, 1'b0);
    idle_bits(2);
    check("glitch_no_valid", valid_n, v0);
    check("glitch_no_err",   err_n,   e0);

    // Reset in the middle of bit 4 of 0xFF.
    v0 = valid_n;
    e0 = err_n;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (4 * DIV + HALF) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_data", rx_data, 8'h00);
    check("midreset_busy", rx_busy, 1'b0);
    rst = 1'b0;
    idle_bits(6);
    check("midreset_no_valid", valid_n, v0);
    check("midreset_no_err",   err_n,   e0);
    send(8'h81, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    idle_bits(1);
    check("after_reset_data", rx_data, 8'h81);

    // Mid-bit spikes: the majority vote rejects them; a single sample does not.
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 8'hF0;
`else
    spike_exp = ~8'hF0;
`endif
    send(8'hF0, 1'b1, 1'b1);
    exp_q.push_back(spike_exp);
    idle_bits(1);
    check("spike_data", rx_data, spike_exp);

    // Random frames with occasional bad stop bits and random idle gaps.
    for (int i = 0; i < 8; i++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      send(b, stop_ok, 1'b0);
      if (stop_ok) exp_q.push_back(b);
      else         exp_err_n++;
      if (!stop_ok || $urandom_range(0, 1) == 1) idle_bits(1 + $urandom_range(0, 1));
    end
    idle_bits(2);

    check("total_valid_n", got_q.size(), exp_q.size());
    check("total_err_n",   err_n,        exp_err_n);
    check("never_both",    both_n,       0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("frame_%0d_data", i), got_q[i], exp_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter clk_freq, default 24000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud, default 1000000, line rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse; rx_data updated in the same cycle.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (initial/reset value 1); all logic uses the synchronized value rxs.
REQ-011 SHALL use DIV = clk_freq/baud (integer, truncated) and HALF = DIV/2; divisor counter width SHALL be $clog2(DIV)+1.
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 IDLE: falling edge of rxs (previous 1, current 0) -> START, counter loaded with HALF-1.
REQ-014 Counter decrements each cycle outside IDLE; "expiry" is the cycle in which counter == 0.
REQ-015 START at expiry: sample 0 -> DATA, counter DIV-1, bit index 0; sample 1 -> IDLE (false start), no output pulse.
REQ-016 DATA at expiry: shift register <= {sample, shift[7:1]} (LSB first), counter DIV-1, index+1; after index 7 -> STOP.
REQ-017 STOP at expiry: sample 1 -> rx_data <= shift, rx_valid pulse; sample 0 -> rx_frame_err pulse, rx_data unchanged; both cases -> IDLE.
REQ-018 rx_valid and rx_frame_err SHALL never be asserted together, and each SHALL be high for exactly one cycle per frame.
REQ-019 After a framing error with the line still low (break), IDLE SHALL NOT start a new frame until rxs has been seen high and then falls.
REQ-020 A new start edge arriving in the same cycle as STOP expiry SHALL be ignored; edges are detected only while in IDLE.
REQ-021 rx_data SHALL hold its value until the next valid frame; no consumer handshake and no overrun detection.
REQ-022 Latency: rx_valid SHALL assert 2 + HALF + 9*DIV clocks (plus or minus 1) after the rx falling edge of the start bit.

Reset
REQ-023 rst SHALL force state IDLE, counter 0, index 0, shift 0, rx_data 0x00, rx_valid 0, rx_frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame without a pulse; after release, the next falling edge starts a fresh frame.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN: when defined, each sample SHALL be the 2-of-3 majority of rxs over the expiry cycle and the two preceding cycles (history reset to 3'b111).
REQ-026 Without UART_RX_MAJORITY_EN, each sample SHALL be rxs in the expiry cycle only; start-edge detection is identical in both builds.

Verification (clk_freq 24000000, baud 1000000: DIV 24, HALF 12)
REQ-027 Send 0x55, stop high -> single rx_valid pulse, rx_data 0x55, rx_frame_err 0, pulse 2+12+216 clocks (plus or minus 1) after the start edge.
REQ-028 Send 0xA3 then 0x00 back-to-back (one stop bit) -> two rx_valid pulses, rx_data 0xA3 then 0x00.
REQ-029 Send 0x7E with the stop bit held low -> rx_frame_err pulse, no rx_valid, rx_data keeps its prior value; line held low 30 bits then idle, then send 0x12 -> rx_data 0x12.
REQ-030 Drive a 5-clock low glitch on an idle line -> START aborts to IDLE, no pulses, rx_busy returns to 0 within 15 clocks.
REQ-031 Assert rst during bit 4 of 0xFF, release, send 0x81 -> no pulse for the aborted frame; rx_data 0x81.
REQ-032 With UART_RX_MAJORITY_EN, send 0xF0 with a 1-clock inverted spike at each sample point -> rx_data 0xF0. Without the macro, the same stimulus corrupts the byte.
